// File: rtl/bcd_digit_converter_pkg.sv
// Display definitions shared by the BCD converter and the seven-segment multiplexer.
package bcd_digit_converter_pkg;

   localparam logic [3:0] DIG_DASH   = 4'd10;
   localparam int unsigned NUM_DIGITS = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LOAD  = 2'd2
   } conv_state_t;

endpackage

// File: rtl/bcd_digit_converter_add3.sv
// Double-dabble nibble corrector: adds 3 to a BCD nibble of 5 or more.
module bcd_add3 (
   input  logic [3:0] nib,
   output logic [3:0] fixed
);

   always_comb begin
      fixed = nib;
      if (nib >= 4'd5)
         fixed = nib + 4'd3;
   end

endmodule

// File: rtl/bcd_digit_converter.sv
// Iterative shift-add-3 binary-to-BCD converter driving four display digits.
module bcd_digit_converter
   import bcd_digit_converter_pkg::*;
#(
   parameter int unsigned W      = 14,
   parameter int unsigned MAXVAL = 9999
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] value,
   output logic         busy,
   output logic         done,
   output logic [3:0]   dig0,
   output logic [3:0]   dig1,
   output logic [3:0]   dig2,
   output logic [3:0]   dig3
);

   localparam int unsigned CW = $clog2(W + 1);

   conv_state_t   state;
   logic [W-1:0]  shreg;
   logic [15:0]   scratch;
   logic [15:0]   corrected;
   logic [CW-1:0] cnt;
   logic          ovf;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .nib   (scratch[4*g +: 4]),
         .fixed (corrected[4*g +: 4])
      );
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         shreg   <= '0;
         scratch <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         dig0    <= '0;
         dig1    <= '0;
         dig2    <= '0;
         dig3    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shreg   <= value;
                  scratch <= '0;
                  cnt     <= '0;
                  ovf     <= (32'(value) > MAXVAL);
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               // Correction and shift happen in the same step: {scratch, shreg} <<= 1 after add-3.
               scratch <= {corrected[14:0], shreg[W-1]};
               shreg   <= {shreg[W-2:0], 1'b0};
               cnt     <= cnt + 1'b1;
               if (cnt == CW'(W - 1))
                  state <= LOAD;
            end
            LOAD: begin
               if (ovf) begin
                  dig0 <= DIG_DASH;
                  dig1 <= DIG_DASH;
                  dig2 <= DIG_DASH;
                  dig3 <= DIG_DASH;
               end else begin
                  dig0 <= scratch[3:0];
                  dig1 <= scratch[7:4];
                  dig2 <= scratch[11:8];
                  dig3 <= scratch[15:12];
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
